// File: rtl/timer_dev.sv
// Memory-mapped programmable down-counter timer with a maskable expiry interrupt.
// Supports one-shot and auto-reload modes; register file sits behind the system bridge.
module timer_dev #(
   parameter int CNT_W = 32
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [1:0]  Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } state_e;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] MODE_RELOAD = 2'd1;

   state_e             state_q, state_d;
   logic               en_q, en_d;
   logic [1:0]         mode_q, mode_d;
   logic               im_q, im_d;
   logic [CNT_W-1:0]   preset_q, preset_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               irq_flag_q, irq_flag_d;

   logic wr_ctrl, wr_preset, reload_mode, count_zero;

   assign wr_ctrl     = WE && (Addr == ADDR_CTRL);
   assign wr_preset   = WE && (Addr == ADDR_PRESET);
   assign reload_mode = (mode_q == MODE_RELOAD);
   assign count_zero  = (count_q == '0);

   // NOTE: state is updated with non-blocking assignments so every register samples
   // the pre-edge values of the others; blocking here would create ordering races.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= S_IDLE;
         en_q       <= 1'b0;
         mode_q     <= 2'd0;
         im_q       <= 1'b0;
         preset_q   <= '0;
         count_q    <= '0;
         irq_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         en_q       <= en_d;
         mode_q     <= mode_d;
         im_q       <= im_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_flag_q <= irq_flag_d;
      end
   end

   // NOTE: every variable driven in always_comb gets a default first so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (en_q) state_d = S_LOAD;
         S_LOAD: state_d = S_CNT;
         S_CNT: begin
            if (!en_q)          state_d = S_IDLE;
            else if (count_zero) state_d = S_INT;
         end
         S_INT:  state_d = reload_mode ? S_LOAD : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM actions first, then CPU writes so a same-cycle store overrides them.
   always_comb begin
      en_d       = en_q;
      mode_d     = mode_q;
      im_d       = im_q;
      preset_d   = preset_q;
      count_d    = count_q;
      irq_flag_d = irq_flag_q;

      unique case (state_q)
         S_LOAD: count_d = preset_q;
         S_CNT: begin
            if (en_q) begin
               if (count_zero) irq_flag_d = 1'b1;
               else            count_d    = count_q - CNT_W'(1);
            end
         end
         S_INT: begin
            if (reload_mode) irq_flag_d = 1'b0;
            else             en_d       = 1'b0;
         end
         default: ;
      endcase

      if (wr_ctrl) begin
         en_d       = Din[0];
         mode_d     = Din[2:1];
         im_d       = Din[3];
         irq_flag_d = 1'b0;
      end
      if (wr_preset) begin
         preset_d   = Din[CNT_W-1:0];
         irq_flag_d = 1'b0;
      end
   end

   always_comb begin
      Dout = 32'd0;
      unique case (Addr)
         ADDR_CTRL:   Dout = {28'd0, im_q, mode_q, en_q};
         ADDR_PRESET: Dout = 32'(preset_q);
         ADDR_COUNT:  Dout = 32'(count_q);
         default:     Dout = 32'd0;
      endcase
   end

   assign IRQ = irq_flag_q & im_q;

endmodule
